// File: rtl/bru_pkg.sv
// Shared constants for the branch resolve unit: opcodes, branch funct3 codes,
// FSM state encoding and store-type encodings.
package bru_pkg;

   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_JALR   = 5'b11001;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [1:0] MEMRW_NONE = 2'b00;
   localparam logic [1:0] MEMRW_SB   = 2'b01;
   localparam logic [1:0] MEMRW_SH   = 2'b10;
   localparam logic [1:0] MEMRW_SW   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_SHADOW   = 2'd2
   } bru_state_e;

   // Saturating 32-bit increment used by the optional statistics counters.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/bru_dir_resolve.sv
// Combinational branch/jump classification and resolved direction for the
// EX-stage instruction.
module bru_dir_resolve
   import bru_pkg::*;
(
   input  logic [31:0] inst,
   input  logic        br_eq,
   input  logic        br_lt,
   output logic        is_branch,
   output logic        is_jump,
   output logic        actual_taken
);

   logic [4:0] opcode;
   logic [2:0] funct3;
   logic       br_dir;
   logic       unused_inst_bits;

   assign opcode = inst[6:2];
   assign funct3 = inst[14:12];
   assign unused_inst_bits = ^{inst[31:15], inst[11:7], inst[1:0]};

   assign is_branch = (opcode == OP_BRANCH);
   assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);

   // funct3 010/011 are not branch encodings; they resolve as not-taken.
   always_comb begin
      br_dir = 1'b0;
      case (funct3)
         F3_BEQ:  br_dir = br_eq;
         F3_BNE:  br_dir = ~br_eq;
         F3_BLT:  br_dir = br_lt;
         F3_BGE:  br_dir = ~br_lt;
         F3_BLTU: br_dir = br_lt;
         F3_BGEU: br_dir = ~br_lt;
         default: br_dir = 1'b0;
      endcase
   end

   assign actual_taken = is_jump | (is_branch & br_dir);

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: detects mispredicts, pulses a redirect and
// squashes wrong-path control for FLUSH_DEPTH cycles. Optional BRU_STATS_EN.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int FLUSH_DEPTH  = 3,
   parameter int CNT_W        = 4,
   parameter int PREDICT_MODE = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_valid,
   input  logic [31:0] inst,
   input  logic        br_eq,
   input  logic        br_lt,
   input  logic        pred_taken,
   input  logic        hold_in,
   input  logic [1:0]  memrw_in,
   input  logic        regwen_in,
   input  logic [2:0]  ldsel_in,
   input  logic [1:0]  wbsel_in,
   input  logic        csrsel_in,
   output logic [1:0]  memrw_ex,
   output logic        regwen_ex_reg,
   output logic [2:0]  ldsel_ex_reg,
   output logic [1:0]  wbsel_ex_reg,
   output logic        csrsel_ex_reg,
   output logic        pc_sel,
   output logic        redirect_taken,
   output logic        flush_active
`ifdef BRU_STATS_EN
   ,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_jumps,
   output logic [31:0] stat_mispredicts
`endif
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_DEPTH - 1);

   bru_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic             is_branch;
   logic             is_jump;
   logic             actual_taken;
   logic             pred;
   logic             qualify;
   logic             mispredict;

   bru_dir_resolve u_dir (
      .inst         (inst),
      .br_eq        (br_eq),
      .br_lt        (br_lt),
      .is_branch    (is_branch),
      .is_jump      (is_jump),
      .actual_taken (actual_taken)
   );

   assign pred       = (PREDICT_MODE != 0) ? pred_taken : 1'b0;
   assign qualify    = inst_valid & ~hold_in & (state == ST_IDLE);
   assign mispredict = qualify & (is_branch | is_jump) & (actual_taken != pred);

   // REDIRECT holds cnt; SHADOW counts it down and exits after the cnt==1 cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         pc_sel         <= 1'b0;
         flush_active   <= 1'b0;
         redirect_taken <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mispredict) begin
                  state          <= ST_REDIRECT;
                  cnt            <= CNT_INIT;
                  pc_sel         <= 1'b1;
                  flush_active   <= 1'b1;
                  redirect_taken <= actual_taken;
               end
            end
            ST_REDIRECT: begin
               pc_sel <= 1'b0;
               if (cnt != '0) begin
                  state <= ST_SHADOW;
               end else begin
                  state        <= ST_IDLE;
                  flush_active <= 1'b0;
               end
            end
            ST_SHADOW: begin
               if (cnt == CNT_W'(1)) begin
                  state        <= ST_IDLE;
                  cnt          <= '0;
                  flush_active <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state        <= ST_IDLE;
               cnt          <= '0;
               pc_sel       <= 1'b0;
               flush_active <= 1'b0;
            end
         endcase
      end
   end

   assign memrw_ex = (flush_active | hold_in) ? MEMRW_NONE : memrw_in;

   // A held bubble only loses its side effects; its select fields still pass.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regwen_ex_reg <= 1'b0;
         ldsel_ex_reg  <= '0;
         wbsel_ex_reg  <= '0;
         csrsel_ex_reg <= 1'b0;
      end else begin
         regwen_ex_reg <= (flush_active | hold_in) ? 1'b0 : regwen_in;
         ldsel_ex_reg  <= flush_active ? 3'd0 : ldsel_in;
         wbsel_ex_reg  <= flush_active ? 2'd0 : wbsel_in;
         csrsel_ex_reg <= flush_active ? 1'b0 : csrsel_in;
      end
   end

`ifdef BRU_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_jumps       <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (qualify & is_branch) stat_branches    <= sat_inc(stat_branches);
         if (qualify & is_jump)   stat_jumps       <= sat_inc(stat_jumps);
         if (mispredict)          stat_mispredicts <= sat_inc(stat_mispredicts);
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: three instances cover
// FLUSH_DEPTH=3/mode 0, FLUSH_DEPTH=3/mode 1 and FLUSH_DEPTH=5/mode 0.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_valid;
   logic [31:0] inst;
   logic        br_eq, br_lt, pred_taken, hold_in;
   logic [1:0]  memrw_in;
   logic        regwen_in;
   logic [2:0]  ldsel_in;
   logic [1:0]  wbsel_in;
   logic        csrsel_in;

   logic [1:0] memrw_a, memrw_b, memrw_c;
   logic       regwen_a, regwen_b, regwen_c;
   logic [2:0] ldsel_a, ldsel_b, ldsel_c;
   logic [1:0] wbsel_a, wbsel_b, wbsel_c;
   logic       csrsel_a, csrsel_b, csrsel_c;
   logic       pcsel_a, pcsel_b, pcsel_c;
   logic       rtk_a, rtk_b, rtk_c;
   logic       flush_a, flush_b, flush_c;
`ifdef BRU_STATS_EN
   logic [31:0] sb_a, sj_a, sm_a, sb_b, sj_b, sm_b, sb_c, sj_c, sm_c;
`endif

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] NOP_INST = 32'h0000_0033;
   localparam logic [31:0] JAL_INST = 32'h0000_006F;

   always #5 clk = ~clk;

   branch_resolve_unit #(.FLUSH_DEPTH(3), .CNT_W(4), .PREDICT_MODE(0)) dut_a (
      .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .br_eq(br_eq),
      .br_lt(br_lt), .pred_taken(pred_taken), .hold_in(hold_in), .memrw_in(memrw_in),
      .regwen_in(regwen_in), .ldsel_in(ldsel_in), .wbsel_in(wbsel_in), .csrsel_in(csrsel_in),
      .memrw_ex(memrw_a), .regwen_ex_reg(regwen_a), .ldsel_ex_reg(ldsel_a),
      .wbsel_ex_reg(wbsel_a), .csrsel_ex_reg(csrsel_a), .pc_sel(pcsel_a),
      .redirect_taken(rtk_a), .flush_active(flush_a)
`ifdef BRU_STATS_EN
      , .stat_branches(sb_a), .stat_jumps(sj_a), .stat_mispredicts(sm_a)
`endif
   );

   branch_resolve_unit #(.FLUSH_DEPTH(3), .CNT_W(4), .PREDICT_MODE(1)) dut_b (
      .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .br_eq(br_eq),
      .br_lt(br_lt), .pred_taken(pred_taken), .hold_in(hold_in), .memrw_in(memrw_in),
      .regwen_in(regwen_in), .ldsel_in(ldsel_in), .wbsel_in(wbsel_in), .csrsel_in(csrsel_in),
      .memrw_ex(memrw_b), .regwen_ex_reg(regwen_b), .ldsel_ex_reg(ldsel_b),
      .wbsel_ex_reg(wbsel_b), .csrsel_ex_reg(csrsel_b), .pc_sel(pcsel_b),
      .redirect_taken(rtk_b), .flush_active(flush_b)
`ifdef BRU_STATS_EN
      , .stat_branches(sb_b), .stat_jumps(sj_b), .stat_mispredicts(sm_b)
`endif
   );

   branch_resolve_unit #(.FLUSH_DEPTH(5), .CNT_W(4), .PREDICT_MODE(0)) dut_c (
      .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .br_eq(br_eq),
      .br_lt(br_lt), .pred_taken(pred_taken), .hold_in(hold_in), .memrw_in(memrw_in),
      .regwen_in(regwen_in), .ldsel_in(ldsel_in), .wbsel_in(wbsel_in), .csrsel_in(csrsel_in),
      .memrw_ex(memrw_c), .regwen_ex_reg(regwen_c), .ldsel_ex_reg(ldsel_c),
      .wbsel_ex_reg(wbsel_c), .csrsel_ex_reg(csrsel_c), .pc_sel(pcsel_c),
      .redirect_taken(rtk_c), .flush_active(flush_c)
`ifdef BRU_STATS_EN
      , .stat_branches(sb_c), .stat_jumps(sj_c), .stat_mispredicts(sm_c)
`endif
   );

   function automatic logic [31:0] mk_branch(input logic [2:0] f3);
      return {17'd0, f3, 5'd0, 7'b1100011};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] i, input logic eq, input logic lt,
                        input logic pt, input logic hd, input logic [1:0] mrw, input logic rw,
                        input logic [2:0] ld, input logic [1:0] wb, input logic cs);
      inst_valid = v;  inst = i;  br_eq = eq;  br_lt = lt;  pred_taken = pt;
      hold_in = hd;  memrw_in = mrw;  regwen_in = rw;  ldsel_in = ld;
      wbsel_in = wb;  csrsel_in = cs;
   endtask

   task automatic drive_nop(input logic rw, input logic [2:0] ld, input logic [1:0] wb);
      drive(1'b1, NOP_INST, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, rw, ld, wb, 1'b0);
   endtask

   task automatic settle(input int n);
      drive_nop(1'b0, 3'd0, 2'd0);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'd7, 2'd3, 1'b1);
      step();
      step();
      checks++;
      if ({pcsel_a, rtk_a, flush_a, regwen_a, ldsel_a, wbsel_a, csrsel_a} !== 10'd0) begin
         $display("FAIL reset_regs_a got=%b exp=0",
                  {pcsel_a, rtk_a, flush_a, regwen_a, ldsel_a, wbsel_a, csrsel_a});
         failures++;
      end
      checks++;
      if ({pcsel_c, flush_c, regwen_c, ldsel_c} !== 6'd0) begin
         $display("FAIL reset_regs_c got=%b exp=0", {pcsel_c, flush_c, regwen_c, ldsel_c});
         failures++;
      end
      #3 rst = 1'b0;
      settle(2);
   endtask

   task automatic test_beq_mispredict();
      drive(1'b1, mk_branch(3'b000), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'd2, 2'd1, 1'b0);
      step();
      checks++;
      if ({pcsel_a, rtk_a, flush_a} !== 3'b111) begin
         $display("FAIL beq_redirect got=%b exp=111", {pcsel_a, rtk_a, flush_a});
         failures++;
      end
      checks++;
      if ({regwen_a, ldsel_a} !== {1'b1, 3'd2}) begin
         $display("FAIL beq_own_pass got=%h exp=%h", {regwen_a, ldsel_a}, {1'b1, 3'd2});
         failures++;
      end
      drive(1'b1, NOP_INST, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 3'd1, 2'd2, 1'b1);
      #1;
      checks++;
      if (memrw_a !== 2'b00) begin
         $display("FAIL beq_memrw_squash got=%b exp=00", memrw_a);
         failures++;
      end
      for (int k = 2; k <= 4; k++) begin
         step();
         checks++;
         if ({pcsel_a, flush_a, regwen_a, ldsel_a, csrsel_a} !==
             {1'b0, (k < 4), 1'b0, 3'd0, 1'b0}) begin
            $display("FAIL beq_window_e%0d got=%b exp=%b", k,
                     {pcsel_a, flush_a, regwen_a, ldsel_a, csrsel_a},
                     {1'b0, (k < 4), 1'b0, 3'd0, 1'b0});
            failures++;
         end
      end
      #1;
      checks++;
      if (memrw_a !== 2'b11) begin
         $display("FAIL beq_memrw_after got=%b exp=11", memrw_a);
         failures++;
      end
      step();
      checks++;
      if ({regwen_a, ldsel_a, wbsel_a} !== {1'b1, 3'd1, 2'd2}) begin
         $display("FAIL beq_resume got=%h exp=%h", {regwen_a, ldsel_a, wbsel_a},
                  {1'b1, 3'd1, 2'd2});
         failures++;
      end
      settle(8);
   endtask

   task automatic test_bne_not_taken();
      drive(1'b1, mk_branch(3'b001), 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 3'd5, 2'd3, 1'b1);
      #1;
      checks++;
      if (memrw_a !== 2'b11) begin
         $display("FAIL bne_memrw got=%b exp=11", memrw_a);
         failures++;
      end
      step();
      checks++;
      if ({pcsel_a, flush_a, regwen_a, ldsel_a, wbsel_a, csrsel_a} !==
          {1'b0, 1'b0, 1'b1, 3'd5, 2'd3, 1'b1}) begin
         $display("FAIL bne_follow got=%b exp=%b",
                  {pcsel_a, flush_a, regwen_a, ldsel_a, wbsel_a, csrsel_a},
                  {1'b0, 1'b0, 1'b1, 3'd5, 2'd3, 1'b1});
         failures++;
      end
      settle(8);
   endtask

   task automatic test_predict_mode();
      // BLT not taken but predicted taken: mode 1 redirects to fall-through.
      drive(1'b1, mk_branch(3'b100), 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 2'd0, 1'b0);
      step();
      checks++;
      if ({pcsel_b, rtk_b, flush_b} !== 3'b101) begin
         $display("FAIL blt_pred_fallthru got=%b exp=101", {pcsel_b, rtk_b, flush_b});
         failures++;
      end
      checks++;
      if ({pcsel_a, flush_a} !== 2'b00) begin
         $display("FAIL blt_mode0_ignores_pred got=%b exp=00", {pcsel_a, flush_a});
         failures++;
      end
      settle(8);
      drive(1'b1, mk_branch(3'b100), 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 3'd0, 2'd0, 1'b0);
      step();
      checks++;
      if ({pcsel_b, flush_b, regwen_b} !== 3'b001) begin
         $display("FAIL blt_pred_correct got=%b exp=001", {pcsel_b, flush_b, regwen_b});
         failures++;
      end
      checks++;
      if ({pcsel_a, rtk_a} !== 2'b11) begin
         $display("FAIL blt_mode0_taken got=%b exp=11", {pcsel_a, rtk_a});
         failures++;
      end
      settle(8);
   endtask

   task automatic test_jal_window();
      int pulses;
      int flushes;
      drive(1'b1, JAL_INST, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'd0, 2'd2, 1'b0);
      step();
      pulses  = int'(pcsel_c);
      flushes = int'(flush_c);
      checks++;
      if ({regwen_c, wbsel_c, rtk_c} !== {1'b1, 2'd2, 1'b1}) begin
         $display("FAIL jal_link_pass got=%b exp=%b", {regwen_c, wbsel_c, rtk_c},
                  {1'b1, 2'd2, 1'b1});
         failures++;
      end
      drive(1'b1, JAL_INST, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'd0, 2'd2, 1'b0);
      step();
      pulses  += int'(pcsel_c);
      flushes += int'(flush_c);
      checks++;
      if ({regwen_c, wbsel_c} !== 3'b000) begin
         $display("FAIL jal2_squashed got=%b exp=000", {regwen_c, wbsel_c});
         failures++;
      end
      drive_nop(1'b0, 3'd0, 2'd0);
      for (int k = 0; k < 8; k++) begin
         step();
         pulses  += int'(pcsel_c);
         flushes += int'(flush_c);
      end
      checks++;
      if (pulses !== 1) begin
         $display("FAIL jal_pc_sel_pulses got=%0d exp=1", pulses);
         failures++;
      end
      checks++;
      if (flushes !== 5) begin
         $display("FAIL jal_window_len got=%0d exp=5", flushes);
         failures++;
      end
      settle(2);
   endtask

   task automatic test_hold();
      drive(1'b1, NOP_INST, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 3'd4, 2'd2, 1'b1);
      #1;
      checks++;
      if (memrw_a !== 2'b00) begin
         $display("FAIL hold_memrw got=%b exp=00", memrw_a);
         failures++;
      end
      step();
      checks++;
      if ({regwen_a, ldsel_a, wbsel_a, csrsel_a} !== {1'b0, 3'd4, 2'd2, 1'b1}) begin
         $display("FAIL hold_regs got=%b exp=%b", {regwen_a, ldsel_a, wbsel_a, csrsel_a},
                  {1'b0, 3'd4, 2'd2, 1'b1});
         failures++;
      end
      // A held mispredicting branch must not be detected.
      drive(1'b1, mk_branch(3'b000), 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 3'd0, 2'd0, 1'b0);
      step();
      checks++;
      if ({pcsel_a, flush_a} !== 2'b00) begin
         $display("FAIL hold_no_detect got=%b exp=00", {pcsel_a, flush_a});
         failures++;
      end
      settle(8);
   endtask

   task automatic test_reset_mid_window();
      drive(1'b1, mk_branch(3'b000), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'd3, 2'd1, 1'b0);
      step();
      drive_nop(1'b1, 3'd3, 2'd1);
      step();
      checks++;
      if ({flush_a, rtk_a} !== 2'b11) begin
         $display("FAIL rst_pre_window got=%b exp=11", {flush_a, rtk_a});
         failures++;
      end
      drive(1'b1, NOP_INST, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'd3, 2'd1, 1'b1);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({pcsel_a, rtk_a, flush_a, regwen_a, ldsel_a, wbsel_a, csrsel_a, memrw_a} !== 12'd0) begin
         $display("FAIL rst_async got=%b exp=0",
                  {pcsel_a, rtk_a, flush_a, regwen_a, ldsel_a, wbsel_a, csrsel_a, memrw_a});
         failures++;
      end
      step();
      #2 rst = 1'b0;
      drive(1'b1, mk_branch(3'b000), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'd0, 2'd0, 1'b0);
      step();
      checks++;
      if ({pcsel_a, rtk_a, flush_a} !== 3'b111) begin
         $display("FAIL rst_then_detect got=%b exp=111", {pcsel_a, rtk_a, flush_a});
         failures++;
      end
      settle(8);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_beq_mispredict();
      test_bne_not_taken();
      test_predict_mode();
      test_jal_window();
      test_hold();
      test_reset_mid_window();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
